// File: rtl/ser_pkg.sv
// Shared definitions for the serial link stages: FSM state encoding, line levels
// and counter sizing.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// DIV-cycle divider: tick_o marks the last cycle of each serial bit period.
// Counting restarts from zero on clear_i or after each tick.
module bit_timer
    import ser_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = cnt_w(DIV);

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    assign tick_o = (div_cnt_q == CW'(DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (clear_i || tick_o) div_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one word per handshake, framed as
// start bit, WIDTH data bits, stop bit, each bit held DIV cycles.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    bit_cnt_q;
    logic             ser_q, rdy_q, busy_q, done_q;

    logic             tick;
    logic             first_bit, next_bit;
    logic [WIDTH-1:0] sh_shift;

    // Timer is held cleared while idle so START always begins a full bit period.
    bit_timer #(.DIV(DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    // next_bit is the bit that becomes current once sh_q shifts on this tick.
    assign first_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign next_bit  = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
    assign sh_shift  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            ser_q     <= LINE_IDLE;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rdy_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    ser_q     <= LINE_IDLE;
                    bit_cnt_q <= '0;
                    if (in_valid && rdy_q) begin
                        sh_q    <= in_data;
                        state_q <= START;
                        ser_q   <= START_BIT;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        ser_q   <= first_bit;
                    end
                end
                DATA: begin
                    if (tick) begin
                        sh_q <= sh_shift;
                        if (bit_cnt_q == BW'(WIDTH - 1)) begin
                            state_q   <= STOP;
                            ser_q     <= STOP_BIT;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            ser_q     <= next_bit;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        ser_q   <= LINE_IDLE;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ser_q   <= LINE_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = rdy_q;
    assign ser_out  = ser_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializer configurations on a shared clock and reset,
// checked cycle by cycle against hand-derived frames.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic       vld [3];
    logic [7:0] dat [3];
    logic       rdy [3];
    logic       ser [3];
    logic       bsy [3];
    logic       dn  [3];

    int checks = 0;
    int errors = 0;

    // 0: DIV=2 MSB first, 1: DIV=1 LSB first, 2: DIV=1 MSB first
    piso_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));
    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_data(dat[1]),
        .in_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));
    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_data(dat[2]),
        .in_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Line level for frame slot idx: 0 = start, 1..8 = data, 9 = stop.
    function automatic logic expbit(input logic [7:0] d, input bit msb, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return msb ? d[8 - idx] : d[idx - 1];
    endfunction

    // Called at a negedge with in_ready high; returns at a negedge with in_ready high.
    task automatic send_frame(input int n, input logic [7:0] d, input int div,
                              input bit msb, input bit poke);
        vld[n] = 1'b1;
        dat[n] = d;
        @(negedge clk);
        vld[n] = 1'b0;
        for (int k = 1; k <= 10 * div; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 4 * div) begin
                dat[n] = 8'hC3;
                vld[n] = 1'b1;
            end
            if (poke && k == 8 * div) vld[n] = 1'b0;
            chk("frame_ser",  {31'd0, ser[n]}, {31'd0, expbit(d, msb, (k - 1) / div)});
            chk("frame_rdy",  {31'd0, rdy[n]}, 32'd0);
            chk("frame_busy", {31'd0, bsy[n]}, 32'd1);
            chk("frame_done", {31'd0, dn[n]},  32'd0);
        end
        @(negedge clk);
        chk("end_done", {31'd0, dn[n]},  32'd1);
        chk("end_rdy",  {31'd0, rdy[n]}, 32'd1);
        chk("end_busy", {31'd0, bsy[n]}, 32'd0);
        chk("end_ser",  {31'd0, ser[n]}, 32'd1);
        @(negedge clk);
        chk("post_done", {31'd0, dn[n]},  32'd0);
        chk("post_rdy",  {31'd0, rdy[n]}, 32'd1);
    endtask

    logic [22:0] es, er, ed;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end

        // reset values, then in_ready on the first edge after release
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ser",  {31'd0, ser[i]}, 32'd1);
            chk("rst_rdy",  {31'd0, rdy[i]}, 32'd0);
            chk("rst_busy", {31'd0, bsy[i]}, 32'd0);
            chk("rst_done", {31'd0, dn[i]},  32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rel_rdy", {31'd0, rdy[i]}, 32'd1);

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("async_rdy",  {31'd0, rdy[0]}, 32'd0);
        chk("async_ser",  {31'd0, ser[0]}, 32'd1);
        chk("async_busy", {31'd0, bsy[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rel2_rdy", {31'd0, rdy[0]}, 32'd1);

        // single frame A5, DIV=2, MSB first
        send_frame(0, 8'hA5, 2, 1'b1, 1'b0);

        // LSB first 01, DIV=1
        send_frame(1, 8'h01, 1, 1'b0, 1'b0);

        // in_data/in_valid changes during DATA are ignored
        send_frame(0, 8'h3C, 2, 1'b1, 1'b1);

        // back-to-back FF then 00, DIV=1, in_valid held high
        es = 23'b0111111111_1_0000000001_11;
        er = 23'b0000000000_1_0000000000_11;
        ed = 23'b0000000000_1_0000000000_10;
        vld[2] = 1'b1;
        dat[2] = 8'hFF;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1)  dat[2] = 8'h00;
            if (c == 12) vld[2] = 1'b0;
            chk("b2b_ser",  {31'd0, ser[2]}, {31'd0, es[23 - c]});
            chk("b2b_rdy",  {31'd0, rdy[2]}, {31'd0, er[23 - c]});
            chk("b2b_busy", {31'd0, bsy[2]}, {31'd0, ~er[23 - c]});
            chk("b2b_done", {31'd0, dn[2]},  {31'd0, ed[23 - c]});
        end

        // abort during data bit 4 of F0, then a clean 5A frame
        vld[0] = 1'b1;
        dat[0] = 8'hF0;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_pre_ser",  {31'd0, ser[0]}, 32'd0);
        chk("abort_pre_busy", {31'd0, bsy[0]}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_ser",  {31'd0, ser[0]}, 32'd1);
        chk("abort_busy", {31'd0, bsy[0]}, 32'd0);
        chk("abort_done", {31'd0, dn[0]},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_nodone", {31'd0, dn[0]},  32'd0);
            chk("abort_idle",   {31'd0, ser[0]}, 32'd1);
            chk("abort_rdy",    {31'd0, rdy[0]}, 32'd1);
        end
        send_frame(0, 8'h5A, 2, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
